alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
Round-robin controller that shares one ALU instance (registered output, 1-cycle latency) between NUM_REQ requesters. It accepts one command per transaction over a valid/ready handshake and latches its operands. It then drives the ALU for exactly one enabled cycle, captures the result C, and returns it with the requester id over a valid/ready response channel. It sits between the requester blocks and the ALU, and is the only driver of the ALU inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 5, operand width A/B (signed)
OUTPUT_WIDTH, 6, ALU result width
A_OP_WIDTH, 3, a_op width
B_OP_WIDTH, 2, b_op width
ID_WIDTH, $clog2(NUM_REQ), requester id width

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  one-hot grant/accept
req_a_en, req_b_en  in  NUM_REQ each  per-requester op-enable bits
req_a_op  in  NUM_REQ*A_OP_WIDTH  packed; slice i belongs to requester i
req_b_op  in  NUM_REQ*B_OP_WIDTH  packed
req_A, req_B  in  NUM_REQ*DATA_WIDTH each  packed operands
alu_en  out  1  ALU system enable
alu_a_en, alu_b_en  out  1 each  to ALU
alu_a_op  out  A_OP_WIDTH  to ALU
alu_b_op  out  B_OP_WIDTH  to ALU
alu_A, alu_B  out  DATA_WIDTH each  to ALU
alu_C  in  OUTPUT_WIDTH  ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_WIDTH  granted requester index
rsp_data  out  OUTPUT_WIDTH  captured result
rsp_err  out  1  command had a_en=b_en=0
busy  out  1  state != IDLE

Behaviour:
- Reset: every output is 0. State = IDLE, RR pointer = 0, operand/result registers = 0. rst asserted mid-transaction aborts it: no response, no further ALU enable.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any req_valid, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ. req_ready[g]=1 for that cycle only (combinational from state and req_valid). Latch slice g of all req_* fields and g into rsp_id. Pointer <= (g+1) mod NUM_REQ.
  - Latched a_en=b_en=0: go to RESP with rsp_data=0 and rsp_err=1. The ALU is never enabled.
  - Otherwise go to ISSUE. With no request, stay in IDLE.
- ISSUE (exactly 1 cycle): alu_en=1; alu_* driven from latched fields. Next state CAPTURE.
- CAPTURE: alu_en=0. Register rsp_data <= alu_C; rsp_err <= 0. Next state RESP.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE in the next cycle; no new grant in the handshake cycle.
- alu_* data/op outputs hold their last latched values outside ISSUE. alu_en is 1 only in ISSUE.
- Latency: grant at cycle T, alu_en at T+1, rsp_valid at T+3. Minimum 4 cycles per transaction.
- req_ready is 0 in every state except IDLE. Requesters hold req_valid and payload until granted. Deasserting req_valid before grant is legal and simply removes the request.
- The controller does no arithmetic; widths pass through unchanged.
- Requests that arrive while busy wait. The pointer guarantees each waiting requester is served within NUM_REQ transactions.

Decomposition:
- Package alu_ctrl_pkg: state enum type (IDLE, ISSUE, CAPTURE, RESP), default width localparams, and a command struct {a_en, b_en, a_op, b_op, A, B} used for the latched operand register.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer, and enable; outputs one-hot grant and encoded index. Pure combinational find-first-from-pointer. The pointer register lives in the top.

Test Plan:
- Single add: req 0 valid, a_en=1 b_en=0 a_op=0, A=3 B=4 -> req_ready[0] pulse at T, alu_en only at T+1, rsp_valid at T+3 with rsp_data=6'd7, rsp_id=0, rsp_err=0.
- Signed sub and combined ops: A=-3 (5'b11101), B=2, a_op=1 -> rsp_data=6'h3B. Then a_en=b_en=1, b_op=3, B=15 -> 6'd17. Then b_op=2, A=0 -> 6'h3F.
- Fairness: all 4 req_valid held high with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Each transaction is 4 cycles apart. Exactly one req_ready bit per grant.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; req_ready stays 0 and busy=1. Release -> IDLE next cycle.
- Illegal command: a_en=b_en=0 on req 2 -> alu_en never asserts, rsp_valid 1 cycle after grant with rsp_data=0, rsp_err=1, rsp_id=2.
- Reset mid-op: assert rst during CAPTURE -> all outputs 0 immediately (async). After release there is no stale response, and the first grant goes to the lowest valid index from pointer 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and default widths for the ALU request arbiter
package alu_ctrl_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_WIDTH_DEF = 5;
  localparam int OUTPUT_WIDTH_DEF = 6;
  localparam int A_OP_WIDTH_DEF = 3;
  localparam int B_OP_WIDTH_DEF = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
  typedef struct packed {
    logic                      a_en;
    logic                      b_en;
    logic [A_OP_WIDTH_DEF-1:0] a_op;
    logic [B_OP_WIDTH_DEF-1:0] b_op;
    logic [DATA_WIDTH_DEF-1:0] A;
    logic [DATA_WIDTH_DEF-1:0] B;
  } cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational find-first-set starting at a rotating pointer
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  input  logic                en_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] idx_o
);
  // Scan farthest-first so the last hit is the one closest to the pointer
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (en_i && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
        idx_o = ID_WIDTH'((int'(ptr_i) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one registered-output ALU among requesters
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int A_OP_WIDTH   = A_OP_WIDTH_DEF,
  parameter int B_OP_WIDTH   = B_OP_WIDTH_DEF,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_a_en,
  input  logic [NUM_REQ-1:0]               req_b_en,
  input  logic [NUM_REQ*A_OP_WIDTH-1:0]    req_a_op,
  input  logic [NUM_REQ*B_OP_WIDTH-1:0]    req_b_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_A,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_B,
  output logic                             alu_en,
  output logic                             alu_a_en,
  output logic                             alu_b_en,
  output logic [A_OP_WIDTH-1:0]            alu_a_op,
  output logic [B_OP_WIDTH-1:0]            alu_b_op,
  output logic [DATA_WIDTH-1:0]            alu_A,
  output logic [DATA_WIDTH-1:0]            alu_B,
  input  logic [OUTPUT_WIDTH-1:0]          alu_C,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [OUTPUT_WIDTH-1:0]          rsp_data,
  output logic                             rsp_err,
  output logic                             busy
);
  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d, rsp_id_q, rsp_id_d, idx;
  logic [NUM_REQ-1:0]      gnt;
  cmd_t                    cmd_q, cmd_d, cmd_sel;
  logic [OUTPUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  // Grants are masked during reset so every output reads 0 while rst is high
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .en_i (state_q == IDLE && !rst),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  always_comb begin
    cmd_sel.a_en = req_a_en[idx];
    cmd_sel.b_en = req_b_en[idx];
    cmd_sel.a_op = req_a_op[idx*A_OP_WIDTH +: A_OP_WIDTH];
    cmd_sel.b_op = req_b_op[idx*B_OP_WIDTH +: B_OP_WIDTH];
    cmd_sel.A    = req_A[idx*DATA_WIDTH +: DATA_WIDTH];
    cmd_sel.B    = req_B[idx*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cmd_d      = cmd_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: if (|gnt) begin
        cmd_d    = cmd_sel;
        rsp_id_d = idx;
        ptr_d    = (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        // A command with neither operand enabled is answered without touching the ALU
        state_d    = (cmd_sel.a_en || cmd_sel.b_en) ? ISSUE : RESP;
        rsp_data_d = (cmd_sel.a_en || cmd_sel.b_en) ? rsp_data_q : '0;
        rsp_err_d  = !(cmd_sel.a_en || cmd_sel.b_en);
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        rsp_data_d = alu_C;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      RESP:    state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cmd_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cmd_q      <= cmd_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  assign req_ready = gnt;
  assign alu_en    = state_q == ISSUE;
  assign alu_a_en  = cmd_q.a_en;
  assign alu_b_en  = cmd_q.b_en;
  assign alu_a_op  = cmd_q.a_op;
  assign alu_b_op  = cmd_q.b_op;
  assign alu_A     = cmd_q.A;
  assign alu_B     = cmd_q.B;
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = state_q != IDLE;
endmodule
